// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl
//   Sequences a microwave magnetron through IDLE -> HEAT -> DONE. It counts
//   the cook time down on a 1 Hz tick. It drives one-cycle set/reset pulses
//   into a downstream SR latch that actually switches the magnetron.
//
//   Optional feature macro: PAUSE_RESUME_EN
//     defined   : opening the door while heating enters PAUSE and keeps the
//                 remaining time, so a later start resumes the cook.
//     undefined : opening the door while heating aborts the cook to IDLE.
//                 PAUSE can never be reached in this build.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   start / resume request
//   stop       in   cancel request
//   door_open  in   door sensor level, 1 = open
//   tick       in   one-cycle 1 Hz countdown enable
//   time_in    in   [TW] cook time in seconds, loaded when a cook starts
//   set        out  one-cycle pulse: magnetron on
//   reset      out  one-cycle pulse: magnetron off
//   heating    out  high while in HEAT
//   done       out  high while in DONE
//   remaining  out  [TW] seconds left in the cook
module magnetron_ctrl #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          door_open,
  input  logic          tick,
  input  logic [TW-1:0] time_in,
  output logic          set,
  output logic          reset,
  output logic          heating,
  output logic          done,
  output logic [TW-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, HEAT, PAUSE, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] remaining_nxt;
  logic          set_nxt;
  logic          reset_nxt;
  logic          heating_nxt;
  logic          done_nxt;

  // State register. Every output is also registered here, so each output
  // takes its new value on the same edge as the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      set       <= 1'b0;
      reset     <= 1'b0;
      heating   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      set       <= set_nxt;
      reset     <= reset_nxt;
      heating   <= heating_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic. Within HEAT, the door has the highest priority, then
  // stop, then tick. A tick that arrives with one second or less left ends
  // the cook, so the count can never wrap below zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && !door_open && (time_in != '0))
          state_nxt = HEAT;
      end
      HEAT: begin
        if (door_open) begin
`ifdef PAUSE_RESUME_EN
          state_nxt = PAUSE;
`else
          state_nxt = IDLE;
`endif
        end else if (stop) begin
          state_nxt = IDLE;
        end else if (tick && (remaining < TW'(2))) begin
          state_nxt = DONE;
        end
      end
      PAUSE: begin
        if (stop)
          state_nxt = IDLE;
        else if (start && !door_open)
          state_nxt = HEAT;
      end
      DONE: begin
        if (start || stop)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, computed from the transition that is about to happen.
  // The pulses are defined purely as edges of the HEAT state: set marks an
  // entry into HEAT and reset marks an exit from it. The two can therefore
  // never coincide. A PAUSE -> IDLE cancel produces no pulse because the
  // magnetron is already off in PAUSE.
  always_comb begin
    set_nxt       = (state_nxt == HEAT) && (state != HEAT);
    reset_nxt     = (state == HEAT) && (state_nxt != HEAT);
    heating_nxt   = (state_nxt == HEAT);
    done_nxt      = (state_nxt == DONE);
    remaining_nxt = remaining;
    if ((state_nxt == IDLE) || (state_nxt == DONE))
      remaining_nxt = '0;
    else if (state == IDLE)
      remaining_nxt = time_in;
    else if ((state == HEAT) && (state_nxt == HEAT) && tick)
      remaining_nxt = remaining - TW'(1);
  end

endmodule
